// File: rtl/tribus_arbiter.sv
// Round-robin arbiter for a tri-state bus: grants one requester at a time, bounds each
// tenure to MAXBURST cycles and keeps every enable low for TURN cycles between tenures.
module tribus_arbiter #(
    parameter int N        = 4,
    parameter int MAXBURST = 8,
    parameter int TURN     = 1,
    localparam int OW      = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_gnt,
    output logic [N-1:0]  o_en,
    output logic [OW-1:0] o_owner,
    output logic          o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURNAROUND
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_en;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_ptr;
    logic [7:0]    r_bcnt;
    logic [3:0]    r_tcnt;

    logic          w_found;
    logic [OW-1:0] w_pick;
    logic [OW-1:0] w_idx;
    logic [N-1:0]  w_onehot;
    logic [OW-1:0] w_nextPtr;
    logic          w_release;

    // Scan offsets from the top down so the smallest offset from r_ptr is the last to win.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = OW'((int'(r_ptr) + k) % N);
            if (i_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_pick;
    assign w_nextPtr = (w_pick == OW'(N - 1)) ? '0 : w_pick + 1'b1;
    assign w_release = !i_req[r_owner] || (r_bcnt == 8'(MAXBURST));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_en    <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            case (r_state)
                GRANT: begin
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_en    <= '0;
                        r_tcnt  <= 4'(TURN - 1);
                        r_state <= TURNAROUND;
                    end else begin
                        r_bcnt <= r_bcnt + 8'd1;
                    end
                end
                default: begin
                    // IDLE and an expired turnaround share the same arbitration step.
                    if (r_state == TURNAROUND && r_tcnt != 4'd0) begin
                        r_tcnt <= r_tcnt - 4'd1;
                    end else if (w_found) begin
                        r_gnt   <= w_onehot;
                        r_en    <= w_onehot;
                        r_owner <= w_pick;
                        r_bcnt  <= 8'd1;
                        r_ptr   <= w_nextPtr;
                        r_state <= GRANT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign o_gnt   = r_gnt;
    assign o_en    = r_en;
    assign o_owner = r_owner;
    assign o_busy  = |r_gnt;

endmodule
